// File: rtl/cpu_pkg.sv
// Shared definitions for the MIPS-subset pipeline: reset PC, NOP encoding,
// fetch FSM states and the IF/ID bundle consumed by the decode stage.
package cpu_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
    } if_id_t;

endpackage : cpu_pkg

// File: rtl/if_id_reg.sv
// Generic pipeline register for the IF/ID bundle.
// Flush has priority over load; flushing turns the slot into a NOP bubble
// and leaves the PC fields as they were (they are meaningless while invalid).
module if_id_reg
    import cpu_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   load,
    input  logic   flush,
    input  if_id_t d,
    output if_id_t q
);

    if_id_t bundle_q;

    // Register update: reset clears, flush inserts a bubble, load captures, else hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bundle_q <= '0;
        end else if (flush) begin
            bundle_q.valid <= 1'b0;
            bundle_q.instr <= NOP_INSTR;
        end else if (load) begin
            bundle_q <= d;
        end
    end

    assign q = bundle_q;

endmodule : if_id_reg

// File: rtl/instr_fetch_stage.sv
// Fetch stage: owns the PC, addresses the combinational instruction ROM,
// fills the IF/ID register and runs the RUN/HALT fetch FSM used for the
// syscall halt/resume of the snake program.
module instr_fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = cpu_pkg::RESET_PC,
    parameter int          ADDR_W   = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_target,
    input  logic              halt_req,
    input  logic              resume,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [31:0]       rom_data,
    output logic [31:0]       pc,
    output logic              id_valid,
    output logic [31:0]       id_instr,
    output logic [31:0]       id_pc,
    output logic [31:0]       id_pc4,
    output logic              halted,
    output logic [31:0]       fetch_count
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  fetch_count_q, fetch_count_d;
    logic [31:0]  pc_plus4;

    logic         ifid_load;
    logic         ifid_flush;
    if_id_t       ifid_d;
    if_id_t       ifid_q;

    assign pc_plus4 = pc_q + 32'd4;

    // State registers: FSM, PC and accepted-instruction counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= RUN;
            pc_q          <= RESET_PC;
            fetch_count_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    // Next-state logic: redirect beats halt beats stall beats sequential fetch.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        fetch_count_d = fetch_count_q;
        ifid_load     = 1'b0;
        ifid_flush    = 1'b0;
        ifid_d        = '{valid: 1'b1, instr: rom_data, pc: pc_q, pc4: pc_plus4};

        unique case (state_q)
            RUN: begin
                if (redirect_valid) begin
                    // Older EX instruction wins; the ID occupant (even a syscall) is squashed.
                    pc_d       = {redirect_target[31:2], 2'b00};
                    ifid_flush = 1'b1;
                end else if (halt_req && ifid_q.valid && !stall) begin
                    // The syscall retires as a bubble; PC keeps the next fetch address.
                    state_d    = HALT;
                    ifid_flush = 1'b1;
                end else if (!stall) begin
                    pc_d          = pc_plus4;
                    ifid_load     = 1'b1;
                    fetch_count_d = fetch_count_q + 32'd1;
                end
            end
            HALT: begin
                // Nothing is fetched while halted; the first fetch follows the return to RUN.
                ifid_flush = 1'b1;
                if (resume) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    if_id_reg u_if_id_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (ifid_load),
        .flush (ifid_flush),
        .d     (ifid_d),
        .q     (ifid_q)
    );

    assign rom_addr    = pc_q[ADDR_W+1:2];
    assign pc          = pc_q;
    assign id_valid    = ifid_q.valid;
    assign id_instr    = ifid_q.instr;
    assign id_pc       = ifid_q.pc;
    assign id_pc4      = ifid_q.pc4;
    assign halted      = (state_q == HALT);
    assign fetch_count = fetch_count_q;

endmodule : instr_fetch_stage

// File: tb/tb_instr_fetch_stage.sv
// Bench for instr_fetch_stage: directed scenarios followed by a random phase,
// all checked against a behavioural fetch model kept in the bench.
module tb_instr_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        halt_req;
    logic        resume;
    logic [9:0]  rom_addr;
    logic [31:0] rom_data;
    logic [31:0] pc;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc4;
    logic        halted;
    logic [31:0] fetch_count;

    logic [31:0] rom [1024];

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    logic [31:0] m_pc;
    logic        m_halted;
    logic        m_valid;
    logic [31:0] m_instr;
    logic [31:0] m_idpc;
    logic [31:0] m_count;

    always #5 clk = ~clk;

    assign rom_data = rom[rom_addr];

    instr_fetch_stage #(.RESET_PC(32'h0), .ADDR_W(10)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .halt_req        (halt_req),
        .resume          (resume),
        .rom_addr        (rom_addr),
        .rom_data        (rom_data),
        .pc              (pc),
        .id_valid        (id_valid),
        .id_instr        (id_instr),
        .id_pc           (id_pc),
        .id_pc4          (id_pc4),
        .halted          (halted),
        .fetch_count     (fetch_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Apply one rising edge to the model using the inputs currently driven.
    task automatic model_step();
        if (!rst_n) begin
            m_pc = 32'h0; m_halted = 1'b0; m_valid = 1'b0;
            m_instr = 32'h0; m_idpc = 32'h0; m_count = 32'h0;
        end else if (m_halted) begin
            m_valid = 1'b0; m_instr = 32'h0;
            if (resume) m_halted = 1'b0;
        end else if (redirect_valid) begin
            m_pc = redirect_target & 32'hFFFF_FFFC;
            m_valid = 1'b0; m_instr = 32'h0;
        end else if (halt_req && m_valid && !stall) begin
            m_halted = 1'b1; m_valid = 1'b0; m_instr = 32'h0;
        end else if (!stall) begin
            m_valid = 1'b1;
            m_instr = rom[(m_pc / 4) % 1024];
            m_idpc  = m_pc;
            m_pc    = m_pc + 4;
            m_count = m_count + 1;
        end
    endtask

    task automatic check_all(input string where);
        chk({where, ":pc"}, pc, m_pc);
        chk({where, ":rom_addr"}, {22'd0, rom_addr}, (m_pc / 4) % 1024);
        chk({where, ":halted"}, {31'd0, halted}, {31'd0, m_halted});
        chk({where, ":id_valid"}, {31'd0, id_valid}, {31'd0, m_valid});
        chk({where, ":id_instr"}, id_instr, m_instr);
        chk({where, ":fetch_count"}, fetch_count, m_count);
        if (m_valid) begin
            chk({where, ":id_pc"}, id_pc, m_idpc);
            chk({where, ":id_pc4"}, id_pc4, m_idpc + 4);
        end
    endtask

    // One clock: edge, model update, then sample on the falling edge.
    task automatic cycle(input string where);
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all(where);
        $display("cycle %-12s rst_n=%b stall=%b redir=%b tgt=%h halt_req=%b resume=%b -> pc=%h valid=%b instr=%h halted=%b count=%0d",
                 where, rst_n, stall, redirect_valid, redirect_target, halt_req, resume,
                 pc, id_valid, id_instr, halted, fetch_count);
    endtask

    task automatic idle_inputs();
        stall = 1'b0; redirect_valid = 1'b0; redirect_target = 32'h0;
        halt_req = 1'b0; resume = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) rom[i] = 32'h1000_0000 + i;
        rst_n = 1'b0;
        idle_inputs();
        m_pc = 32'hx; m_halted = 1'bx; m_valid = 1'bx;
        m_instr = 32'hx; m_idpc = 32'hx; m_count = 32'hx;

        // Reset
        @(negedge clk);
        cycle("reset");
        cycle("reset");
        chk("reset_pc", pc, 32'h0);
        chk("reset_count", fetch_count, 32'h0);

        // Four free-running fetches
        rst_n = 1'b1;
        chk("addr0", {22'd0, rom_addr}, 32'd0);
        cycle("run");
        chk("first_instr", id_instr, 32'h1000_0000);
        cycle("run");
        chk("second_instr", id_instr, 32'h1000_0001);
        chk("second_pc", id_pc, 32'h4);
        cycle("run");
        cycle("run");
        chk("count4", fetch_count, 32'd4);

        // Stall for two cycles at pc 0x10
        stall = 1'b1;
        cycle("stall");
        cycle("stall");
        chk("stall_pc", pc, 32'h10);
        chk("stall_count", fetch_count, 32'd4);
        stall = 1'b0;
        cycle("unstall");
        chk("unstall_idpc", id_pc, 32'h10);

        // Redirect overrides a simultaneous stall; misaligned target truncated
        stall = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h0000_0207;
        cycle("redir_stall");
        chk("redir_pc", pc, 32'h204);
        chk("redir_addr", {22'd0, rom_addr}, 32'h81);
        chk("redir_valid", {31'd0, id_valid}, 32'd0);
        idle_inputs();

        // Move to 0x3C, fetch once so pc = 0x40 with a live ID instruction
        redirect_valid = 1'b1; redirect_target = 32'h3C;
        cycle("to_3c");
        idle_inputs();
        cycle("fetch_3c");

        // Halt, hold for ten cycles, resume
        halt_req = 1'b1;
        cycle("halt");
        halt_req = 1'b0;
        chk("halted", {31'd0, halted}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            stall = i[0]; redirect_valid = i[1]; redirect_target = 32'h800; halt_req = i[2];
            cycle("halted");
        end
        idle_inputs();
        chk("halt_pc", pc, 32'h40);
        resume = 1'b1;
        cycle("resume");
        resume = 1'b0;
        chk("resumed", {31'd0, halted}, 32'd0);
        chk("resume_nofetch", {31'd0, id_valid}, 32'd0);
        cycle("post_resume");
        chk("resume_fetch", id_pc, 32'h40);

        // Halt request loses to a same-cycle redirect
        halt_req = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h100;
        cycle("halt_vs_redir");
        idle_inputs();
        chk("hvr_halted", {31'd0, halted}, 32'd0);
        chk("hvr_pc", pc, 32'h100);

        // ROM aliasing across 4 KB
        redirect_valid = 1'b1; redirect_target = 32'hFFC;
        cycle("to_ffc");
        idle_inputs();
        chk("ffc_addr", {22'd0, rom_addr}, 32'h3FF);
        cycle("past_ffc");
        chk("alias_pc", pc, 32'h1000);
        chk("alias_addr", {22'd0, rom_addr}, 32'h0);

        // 32-bit PC wrap
        redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFC;
        cycle("to_top");
        idle_inputs();
        cycle("wrap");
        chk("wrap_pc", pc, 32'h0);

        // Reset while stalled
        stall = 1'b1;
        cycle("pre_rst");
        rst_n = 1'b0;
        cycle("rst_stall");
        chk("rst_mid_valid", {31'd0, id_valid}, 32'd0);
        chk("rst_mid_count", fetch_count, 32'd0);
        chk("rst_mid_pc", pc, 32'h0);
        rst_n = 1'b1;
        idle_inputs();

        // Random phase
        for (int n = 0; n < 600; n++) begin
            rst_n           = ($urandom_range(0, 99) >= 2);
            stall           = ($urandom_range(0, 3) == 0);
            redirect_valid  = ($urandom_range(0, 9) == 0);
            redirect_target = $urandom;
            halt_req        = ($urandom_range(0, 7) == 0);
            resume          = ($urandom_range(0, 4) == 0);
            cycle("random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_instr_fetch_stage
